uart_boot_ctrl: RTL and testbench
=================================

// Module: uart_boot_ctrl
// PURPOSE
//  Boot-load sequencer between the UART receiver and instruction/data memory in Rev_top.
//  Packs received bytes little-endian into 64-bit words and writes them to consecutive memory words.
//  Detects the end-of-program word, then releases the core from reset and raises programmed.
//  Holds the core in reset during loading and after any load error.
// PARAMETERS
//  MEM_DEPTH   1024                   words of target memory; ADDR_W = $clog2(MEM_DEPTH)
//  END_WORD    64'h0000000000000FFF   terminator word; never written to memory
//  TIMEOUT_CYC 4096                   idle clk cycles before a partial word is discarded
// PORTS
//  clk_in1       in   1       system clock
//  rst           in   1       asynchronous active-high reset
//  rx_valid_i    in   1       one-cycle strobe; rx_byte_i valid
//  rx_byte_i     in   8       received UART byte
//  boot_req_i    in   1       restart loading (honoured in DONE/ERROR only)
//  mem_we_o      out  1       memory write request
//  mem_addr_o    out  ADDR_W  word address
//  mem_wdata_o   out  64      write data
//  mem_ready_i   in   1       memory accepts write this cycle
//  core_rst_o    out  1       core reset, active-high
//  programmed_o  out  1       program loaded, core running
//  error_o       out  1       overrun or memory overflow
//  word_cnt_o    out  ADDR_W+1 words written so far
// BEHAVIOUR
//  Reset: state IDLE, byte_cnt=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, core_rst_o=1,
//   programmed_o=0, error_o=0, word_cnt_o=0, skid buffer empty, timeout counter=0.
//  FSM states: IDLE, COLLECT, WRITE, DONE, ERROR.
//  IDLE: first rx_valid_i stores byte into bits[7:0], byte_cnt=1, go to COLLECT.
//  COLLECT: each rx_valid_i stores rx_byte_i into word bits[8*byte_cnt +: 8], byte_cnt++.
//  Word completion: cycle after the 8th byte is stored (T+1 for an 8th strobe in cycle T):
//   - word==END_WORD -> DONE, no write.
//   - else word_cnt_o==MEM_DEPTH -> ERROR.
//   - else WRITE with mem_we_o=1, mem_addr_o=word_cnt_o[ADDR_W-1:0], mem_wdata_o=word.
//  WRITE: mem_we_o, addr and data are held stable until mem_we_o&&mem_ready_i (write accepted).
//   Next cycle: mem_we_o=0, word_cnt_o++, byte_cnt=0, back to COLLECT.
//   If mem_ready_i is already high, we is high for exactly 1 cycle.
//  Skid buffer: one byte arriving during WRITE is buffered and consumed as byte 0 on return to COLLECT.
//   A second byte arriving during the same WRITE -> ERROR (overrun); the pending write is dropped.
//  Timeout: in COLLECT with byte_cnt!=0, TIMEOUT_CYC consecutive cycles without rx_valid_i
//   -> byte_cnt=0 and the partial word is discarded. State, address and word_cnt_o are unchanged.
//   The counter clears on every rx_valid_i.
//  DONE: programmed_o=1, core_rst_o=0. rx_valid_i is ignored.
//  ERROR: error_o=1, core_rst_o=1, programmed_o=0. rx_valid_i is ignored.
//  boot_req_i in DONE or ERROR: next cycle goes to IDLE with all reset values restored
//   (memory contents untouched). boot_req_i is ignored in IDLE, COLLECT and WRITE.
//  Async rst in any state, including mid-word or mid-WRITE, returns immediately to reset values.
//   A partial word is lost and mem_we_o drops.
//  core_rst_o=1 in IDLE, COLLECT and WRITE.
// TESTING
//  1. Send 2 words plus the END_WORD bytes (8 bytes each, LSB first), mem_ready_i=1.
//     -> Writes addr0/addr1 with exact data; word_cnt_o=2; programmed_o=1 and core_rst_o=0
//        1 cycle after the last terminator byte.
//  2. Hold mem_ready_i=0 for 20 cycles during a write.
//     -> mem_we_o, addr and data stay stable; one write completes; word_cnt_o increments once.
//  3. Send 1 byte during a stalled WRITE.
//     -> Buffered and used as byte0 of the next word. A 2nd byte in the same stall
//        -> error_o=1 and core_rst_o=1.
//  4. Send 3 bytes, idle TIMEOUT_CYC cycles, then send a full word.
//     -> Only the full word is written, at addr 0.
//  5. Send MEM_DEPTH+1 non-terminator words.
//     -> MEM_DEPTH writes, then error_o=1. Pulse boot_req_i -> IDLE, word_cnt_o=0.
//  6. Assert rst after byte 5 of a word.
//     -> All outputs return to reset values immediately; a fresh load completes normally.

Source files
------------

// File: rtl/uart_boot_ctrl.sv
// Boot loader: packs UART bytes LSB-first into 64-bit words and writes them to consecutive memory words.
// A write issues the cycle after the 8th byte. It stalls on mem_ready_i, and one byte may arrive meanwhile (a second one is an overrun).
module uart_boot_ctrl #(
    parameter int          MEM_DEPTH   = 1024,
    parameter logic [63:0] END_WORD    = 64'h0000000000000FFF,
    parameter int          TIMEOUT_CYC = 4096,
    localparam int         ADDR_W      = $clog2(MEM_DEPTH)
) (
    input  logic              clk_in1,
    input  logic              rst,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_byte_i,
    input  logic              boot_req_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [63:0]       mem_wdata_o,
    input  logic              mem_ready_i,
    output logic              core_rst_o,
    output logic              programmed_o,
    output logic              error_o,
    output logic [ADDR_W:0]   word_cnt_o
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        DONE    = 3'd3,
        ERROR   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          byte_cnt_q, byte_cnt_d;
    logic [63:0]         word_q, word_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [63:0]         mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
    logic                skid_vld_q, skid_vld_d;
    logic [7:0]          skid_dat_q, skid_dat_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [63:0]         word_full;

    // The 8th byte completes the word combinationally, so the decision lands one cycle after its strobe.
    assign word_full = {rx_byte_i, word_q[55:0]};

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        word_cnt_d  = word_cnt_q;
        skid_vld_d  = skid_vld_q;
        skid_dat_d  = skid_dat_q;
        tmo_cnt_d   = tmo_cnt_q;

        case (state_q)
            IDLE: begin
                if (rx_valid_i) begin
                    word_d     = {56'd0, rx_byte_i};
                    byte_cnt_d = 3'd1;
                    tmo_cnt_d  = '0;
                    state_d    = COLLECT;
                end
            end
            COLLECT: begin
                if (rx_valid_i) begin
                    tmo_cnt_d = '0;
                    if (byte_cnt_q == 3'd7) begin
                        byte_cnt_d = 3'd0;
                        word_d     = '0;
                        if (word_full == END_WORD) begin
                            state_d = DONE;
                        end else if (word_cnt_q == (ADDR_W+1)'(MEM_DEPTH)) begin
                            state_d = ERROR;
                        end else begin
                            state_d     = WRITE;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = word_cnt_q[ADDR_W-1:0];
                            mem_wdata_d = word_full;
                        end
                    end else begin
                        word_d[{byte_cnt_q, 3'b000} +: 8] = rx_byte_i;
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end else if (byte_cnt_q != 3'd0) begin
                    // A stalled sender leaves a partial word; drop it so the next byte starts a fresh word.
                    if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                        byte_cnt_d = 3'd0;
                        word_d     = '0;
                        tmo_cnt_d  = '0;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    end
                end else begin
                    tmo_cnt_d = '0;
                end
            end
            WRITE: begin
                if (rx_valid_i && skid_vld_q) begin
                    state_d    = ERROR;
                    mem_we_d   = 1'b0;
                    skid_vld_d = 1'b0;
                end else if (mem_ready_i) begin
                    mem_we_d   = 1'b0;
                    word_cnt_d = word_cnt_q + (ADDR_W+1)'(1);
                    tmo_cnt_d  = '0;
                    state_d    = COLLECT;
                    if (skid_vld_q) begin
                        word_d     = {56'd0, skid_dat_q};
                        byte_cnt_d = 3'd1;
                        skid_vld_d = 1'b0;
                    end else if (rx_valid_i) begin
                        word_d     = {56'd0, rx_byte_i};
                        byte_cnt_d = 3'd1;
                    end else begin
                        byte_cnt_d = 3'd0;
                    end
                end else if (rx_valid_i) begin
                    skid_vld_d = 1'b1;
                    skid_dat_d = rx_byte_i;
                end
            end
            DONE, ERROR: begin
                if (boot_req_i) begin
                    state_d     = IDLE;
                    byte_cnt_d  = 3'd0;
                    word_d      = '0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    word_cnt_d  = '0;
                    skid_vld_d  = 1'b0;
                    skid_dat_d  = '0;
                    tmo_cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in1 or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            byte_cnt_q  <= 3'd0;
            word_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            word_cnt_q  <= '0;
            skid_vld_q  <= 1'b0;
            skid_dat_q  <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            word_cnt_q  <= word_cnt_d;
            skid_vld_q  <= skid_vld_d;
            skid_dat_q  <= skid_dat_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign word_cnt_o   = word_cnt_q;
    assign programmed_o = (state_q == DONE);
    assign error_o      = (state_q == ERROR);
    assign core_rst_o   = (state_q != DONE);

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Directed bench for uart_boot_ctrl: byte-level stimulus, a write-capture memory model, hand-computed expectations.
module tb_uart_boot_ctrl;

    localparam int          MEM_DEPTH   = 1024;
    localparam int          ADDR_W      = 10;
    localparam int          TIMEOUT_CYC = 4096;
    localparam logic [63:0] END_WORD    = 64'h0000000000000FFF;

    logic              clk_in1 = 1'b0;
    logic              rst = 1'b1;
    logic              rx_valid_i = 1'b0;
    logic [7:0]        rx_byte_i = 8'd0;
    logic              boot_req_i = 1'b0;
    logic              mem_ready_i = 1'b1;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [63:0]       mem_wdata_o;
    logic              core_rst_o;
    logic              programmed_o;
    logic              error_o;
    logic [ADDR_W:0]   word_cnt_o;

    int                n_tests = 0;
    int                n_fail  = 0;
    int                wr_cnt  = 0;
    int                wr_base;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [63:0]       mem_model [0:MEM_DEPTH-1];

    uart_boot_ctrl #(
        .MEM_DEPTH   (MEM_DEPTH),
        .END_WORD    (END_WORD),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_in1      (clk_in1),
        .rst          (rst),
        .rx_valid_i   (rx_valid_i),
        .rx_byte_i    (rx_byte_i),
        .boot_req_i   (boot_req_i),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ready_i  (mem_ready_i),
        .core_rst_o   (core_rst_o),
        .programmed_o (programmed_o),
        .error_o      (error_o),
        .word_cnt_o   (word_cnt_o)
    );

    always #5 clk_in1 = ~clk_in1;

    // Accepted writes land in the model; pre-edge values are read in the active region.
    always @(posedge clk_in1) begin
        if (!rst && mem_we_o && mem_ready_i) begin
            mem_model[mem_addr_o] = mem_wdata_o;
            last_addr = mem_addr_o;
            wr_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_in1);
        rx_valid_i = 1'b1;
        rx_byte_i  = b;
        @(negedge clk_in1);
        rx_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] w);
        for (int i = 0; i < 8; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic pulse_boot_req();
        @(negedge clk_in1);
        boot_req_i = 1'b1;
        @(negedge clk_in1);
        boot_req_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_in1);
        rst = 1'b1;
        repeat (2) @(negedge clk_in1);
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".we"},    {63'd0, mem_we_o},     64'd0);
        chk({tag, ".addr"},  {54'd0, mem_addr_o},   64'd0);
        chk({tag, ".wdata"}, mem_wdata_o,           64'd0);
        chk({tag, ".crst"},  {63'd0, core_rst_o},   64'd1);
        chk({tag, ".prog"},  {63'd0, programmed_o}, 64'd0);
        chk({tag, ".err"},   {63'd0, error_o},      64'd0);
        chk({tag, ".wcnt"},  {53'd0, word_cnt_o},   64'd0);
    endtask

    initial begin
        #1_000_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] endw;
        logic [63:0] w;
        endw = END_WORD;

        // Reset state
        repeat (2) @(negedge clk_in1);
        chk_reset_outputs("rst0");
        rst = 1'b0;

        // Test 1: two words plus terminator
        wr_base = wr_cnt;
        send_word(64'h0123_4567_89AB_CDEF);
        send_word(64'hFEDC_BA98_7654_3210);
        for (int i = 0; i < 7; i++) send_byte(endw[8*i +: 8]);
        chk("t1.prog_before", {63'd0, programmed_o}, 64'd0);
        send_byte(endw[63:56]);
        chk("t1.prog",  {63'd0, programmed_o}, 64'd1);
        chk("t1.crst",  {63'd0, core_rst_o},   64'd0);
        chk("t1.mem0",  mem_model[0], 64'h0123_4567_89AB_CDEF);
        chk("t1.mem1",  mem_model[1], 64'hFEDC_BA98_7654_3210);
        chk("t1.wcnt",  {53'd0, word_cnt_o}, 64'd2);
        chk("t1.nwr",   64'(wr_cnt - wr_base), 64'd2);
        send_byte(8'h55);
        chk("t1.ignore_rx", {53'd0, word_cnt_o}, 64'd2);
        pulse_boot_req();
        chk_reset_outputs("t1.boot");

        // Tests 2/3: stalled write, one buffered byte, then overrun
        wr_base = wr_cnt;
        mem_ready_i = 1'b0;
        send_word(64'h1111_2222_3333_4444);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in1);
            chk("t2.we_hold",   {63'd0, mem_we_o},   64'd1);
            chk("t2.addr_hold", {54'd0, mem_addr_o}, 64'd0);
            chk("t2.data_hold", mem_wdata_o, 64'h1111_2222_3333_4444);
        end
        chk("t2.no_wr", 64'(wr_cnt - wr_base), 64'd0);
        send_byte(8'h10);
        chk("t3.skid_noerr", {63'd0, error_o}, 64'd0);
        chk("t3.skid_we",    {63'd0, mem_we_o}, 64'd1);
        @(negedge clk_in1);
        mem_ready_i = 1'b1;
        @(negedge clk_in1);
        chk("t2.we_drop", {63'd0, mem_we_o}, 64'd0);
        chk("t2.wcnt",    {53'd0, word_cnt_o}, 64'd1);
        chk("t2.nwr",     64'(wr_cnt - wr_base), 64'd1);
        chk("t2.mem0",    mem_model[0], 64'h1111_2222_3333_4444);
        w = 64'h1716_1514_1312_1110;
        for (int i = 1; i < 8; i++) send_byte(w[8*i +: 8]);
        @(negedge clk_in1);
        chk("t3.mem1", mem_model[1], 64'h1716_1514_1312_1110);
        chk("t3.wcnt", {53'd0, word_cnt_o}, 64'd2);
        mem_ready_i = 1'b0;
        send_word(64'h5555_6666_7777_8888);
        send_byte(8'hA1);
        send_byte(8'hA2);
        chk("t3.err",  {63'd0, error_o},    64'd1);
        chk("t3.crst", {63'd0, core_rst_o}, 64'd1);
        chk("t3.we",   {63'd0, mem_we_o},   64'd0);
        chk("t3.wcnt_err", {53'd0, word_cnt_o}, 64'd2);
        chk("t3.nwr",  64'(wr_cnt - wr_base), 64'd2);
        mem_ready_i = 1'b1;
        pulse_boot_req();
        chk_reset_outputs("t3.boot");

        // Test 4: partial word discarded on timeout
        wr_base = wr_cnt;
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        repeat (TIMEOUT_CYC + 2) @(negedge clk_in1);
        send_word(64'h0807_0605_0403_0201);
        @(negedge clk_in1);
        chk("t4.nwr",  64'(wr_cnt - wr_base), 64'd1);
        chk("t4.addr", {54'd0, last_addr}, 64'd0);
        chk("t4.mem0", mem_model[0], 64'h0807_0605_0403_0201);
        chk("t4.wcnt", {53'd0, word_cnt_o}, 64'd1);
        pulse_boot_req();
        chk("t4.boot_ignored", {53'd0, word_cnt_o}, 64'd1);
        do_reset();

        // Test 5: memory overflow
        wr_base = wr_cnt;
        for (int i = 0; i <= MEM_DEPTH; i++) send_word({32'hC0DE_0000, 32'(i)});
        @(negedge clk_in1);
        chk("t5.nwr",   64'(wr_cnt - wr_base), 64'd1024);
        chk("t5.err",   {63'd0, error_o}, 64'd1);
        chk("t5.wcnt",  {53'd0, word_cnt_o}, 64'd1024);
        chk("t5.last",  {54'd0, last_addr}, 64'd1023);
        chk("t5.mem0",  mem_model[0],    64'hC0DE_0000_0000_0000);
        chk("t5.mem1023", mem_model[1023], 64'hC0DE_0000_0000_03FF);
        pulse_boot_req();
        chk_reset_outputs("t5.boot");

        // Test 6: async reset mid-word and mid-write, then a clean load
        send_word(64'h2222_3333_4444_5555);
        @(negedge clk_in1);
        chk("t6.wcnt_pre", {53'd0, word_cnt_o}, 64'd1);
        for (int i = 0; i < 5; i++) send_byte(8'h90 + 8'(i));
        #2 rst = 1'b1;
        #1 chk_reset_outputs("t6.rst_mid");
        @(negedge clk_in1);
        rst = 1'b0;
        mem_ready_i = 1'b0;
        send_word(64'h9999_8888_7777_6666);
        chk("t6.we_stall", {63'd0, mem_we_o}, 64'd1);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("t6.rst_write");
        @(negedge clk_in1);
        rst = 1'b0;
        mem_ready_i = 1'b1;
        wr_base = wr_cnt;
        send_word(64'hDEAD_BEEF_0BAD_F00D);
        send_word(END_WORD);
        chk("t6.mem0", mem_model[0], 64'hDEAD_BEEF_0BAD_F00D);
        chk("t6.nwr",  64'(wr_cnt - wr_base), 64'd1);
        chk("t6.prog", {63'd0, programmed_o}, 64'd1);
        chk("t6.crst", {63'd0, core_rst_o}, 64'd0);
        chk("t6.wcnt", {53'd0, word_cnt_o}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
